// File: rtl/updown_pkg.sv
// Shared definitions for the up/down sweep controller and its counter core.
//   state_t   : controller state encoding (IDLE..DWELL_LO)
//   MODE_UP   : counter counts up
//   MODE_DOWN : counter counts down
package updown_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEEK     = 3'd1,
    UP       = 3'd2,
    DWELL_HI = 3'd3,
    DOWN     = 3'd4,
    DWELL_LO = 3'd5
  } state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/updown_counter_core.sv
// WIDTH-bit synchronous up/down counter.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high (q -> 0)
//   t_en : advance q this cycle
//   mode : MODE_UP increments, MODE_DOWN decrements (mod 2^WIDTH)
//   q    : counter value
module updown_counter_core
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_en,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (t_en) begin
      q <= (mode == MODE_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle sweep sequencer: drives an up/down counter so q walks lo..hi..lo
// repeatedly, with an optional dwell at each bound, a sweep count and abort.
//   clk, rst  : clock and synchronous active-high reset
//   start     : begin a run (IDLE only); lo/hi/n_sweeps captured here
//   stop      : abort a run; wins over start
//   lo, hi    : sweep bounds (lo > hi rejects the start with err)
//   n_sweeps  : sweeps per run, 0 = run until stop
//   q         : counter value
//   t_en/mode : counter step command for this cycle (combinational)
//   busy      : run in progress
//   sweep_cnt : completed sweeps in the current run (saturating)
//   done/err  : one-cycle pulses for run completion / rejected start
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 2,
  parameter int unsigned DW_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] n_sweeps,
  output logic [WIDTH-1:0] q,
  output logic             t_en,
  output logic             mode,
  output logic             busy,
  output logic [WIDTH-1:0] sweep_cnt,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  // Dwell counter loads DWELL-1 so the dwell state lasts exactly DWELL cycles.
  localparam logic [DW_W-1:0]  DW_LOAD = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

  state_t           state, state_d;
  logic [WIDTH-1:0] lo_r, lo_d;
  logic [WIDTH-1:0] hi_r, hi_d;
  logic [WIDTH-1:0] n_r, n_d;
  logic [DW_W-1:0]  dw_cnt, dw_d;
  logic [WIDTH-1:0] sweep_d;
  logic             done_d, err_d;

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .rst  (rst),
    .t_en (t_en),
    .mode (mode),
    .q    (q)
  );

  assign busy = (state != IDLE);

  // State and run-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lo_r      <= '0;
      hi_r      <= '0;
      n_r       <= '0;
      dw_cnt    <= '0;
      sweep_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      lo_r      <= lo_d;
      hi_r      <= hi_d;
      n_r       <= n_d;
      dw_cnt    <= dw_d;
      sweep_cnt <= sweep_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Next-state and counter command.
  always_comb begin
    state_d = state;
    lo_d    = lo_r;
    hi_d    = hi_r;
    n_d     = n_r;
    dw_d    = dw_cnt;
    sweep_d = sweep_cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    t_en    = 1'b0;
    mode    = MODE_UP;

    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (lo <= hi) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            sweep_d = '0;
            state_d = SEEK;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SEEK: begin
        mode = (q > lo_r) ? MODE_DOWN : MODE_UP;
        if (q != lo_r) begin
          t_en = 1'b1;
        end else begin
          state_d = UP;
        end
      end

      UP: begin
        mode = MODE_UP;
        if (q != hi_r) begin
          t_en = 1'b1;
        end else if (DWELL > 0) begin
          state_d = DWELL_HI;
          dw_d    = DW_LOAD;
        end else begin
          state_d = DOWN;
        end
      end

      DWELL_HI: begin
        if (dw_cnt == '0) begin
          state_d = DOWN;
        end else begin
          dw_d = dw_cnt - DW_W'(1);
        end
      end

      DOWN: begin
        mode = MODE_DOWN;
        if (q != lo_r) begin
          t_en = 1'b1;
        end else begin
          sweep_d = (sweep_cnt == CNT_MAX) ? sweep_cnt : sweep_cnt + WIDTH'(1);
          if ((n_r != '0) && (sweep_cnt + WIDTH'(1) == n_r)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (DWELL > 0) begin
            state_d = DWELL_LO;
            dw_d    = DW_LOAD;
          end else begin
            state_d = UP;
          end
        end
      end

      DWELL_LO: begin
        if (dw_cnt == '0) begin
          state_d = UP;
        end else begin
          dw_d = dw_cnt - DW_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Abort: freeze q and the sweep count, and suppress any completion.
    if (stop && (state != IDLE)) begin
      t_en    = 1'b0;
      state_d = IDLE;
      sweep_d = sweep_cnt;
      done_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: a DWELL=2 and a DWELL=0 instance share one
// stimulus stream. On each accepted start the reference builds the whole
// expected q / sweep_cnt trajectory of the run as a per-cycle list.
module tb_updown_sweep_ctrl;

  localparam int CAP = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [3:0] n_sweeps = '0;

  logic [1:0][3:0] q_o, sc_o;
  logic [1:0]      ten_o, mode_o, busy_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  // Reference state per instance (0: DWELL=2, 1: DWELL=0).
  int         dwell_of [2] = '{2, 0};
  logic [3:0] rq  [2][CAP];
  logic [3:0] rsc [2][CAP];
  int         m_len [2];
  int         m_idx [2];
  bit         m_busy [2];
  bit         m_done [2];
  bit         m_err  [2];
  logic [3:0] m_q   [2];
  logic [3:0] m_sc  [2];
  logic [3:0] m_fsc [2];
  logic [3:0] m_n   [2];

  int t2_exp [14] = '{0, 1, 2, 3, 3, 4, 5, 6, 6, 6, 6, 5, 4, 3};

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.WIDTH(4), .DWELL(2), .DW_W(2)) u_dut_d2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .q(q_o[0]), .t_en(ten_o[0]), .mode(mode_o[0]),
    .busy(busy_o[0]), .sweep_cnt(sc_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  updown_sweep_ctrl #(.WIDTH(4), .DWELL(0), .DW_W(2)) u_dut_d0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .q(q_o[1]), .t_en(ten_o[1]), .mode(mode_o[1]),
    .busy(busy_o[1]), .sweep_cnt(sc_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input int qv, input int scv);
    if (m_len[i] < CAP) begin
      rq[i][m_len[i]]  = 4'(qv);
      rsc[i][m_len[i]] = 4'(scv);
      m_len[i]++;
    end
  endtask

  // Whole-run trajectory: seek to lo, then up lo..hi, dwell, down hi..lo, dwell ...
  task automatic build(input int i, input int q0, input int l, input int h, input int n);
    int qq;
    int sc;
    m_len[i] = 0;
    qq = q0;
    while (qq != l) begin
      push(i, qq, 0);
      qq = (qq > l) ? qq - 1 : qq + 1;
    end
    push(i, l, 0);
    sc = 0;
    for (int k = 1; m_len[i] < CAP; k++) begin
      for (int v = l; v <= h; v++) push(i, v, sc);
      for (int d = 0; d < dwell_of[i]; d++) push(i, h, sc);
      for (int v = h; v >= l; v--) push(i, v, sc);
      sc = (sc == 15) ? 15 : sc + 1;
      if (n != 0 && k == n) break;
      for (int d = 0; d < dwell_of[i]; d++) push(i, l, sc);
    end
    m_fsc[i] = 4'(sc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
      m_q[i] = '0; m_sc[i] = '0; m_idx[i] = 0; m_len[i] = 0; m_n[i] = '0;
    end
  endtask

  // Compare both instances against the reference, then advance it one cycle.
  task automatic eval_cycle();
    for (int i = 0; i < 2; i++) begin
      int    e_q, e_sc, nxt;
      bit    e_ten, e_mode, e_busy, e_done, e_err;
      string p;
      p = (i == 0) ? "d2" : "d0";
      if (m_busy[i]) begin
        e_q    = int'(rq[i][m_idx[i]]);
        e_sc   = int'(rsc[i][m_idx[i]]);
        nxt    = (m_idx[i] + 1 < m_len[i]) ? int'(rq[i][m_idx[i] + 1]) : e_q;
        e_ten  = !stop && (nxt != e_q);
        e_mode = (nxt < e_q);
        e_busy = 1; e_done = 0; e_err = 0;
      end else begin
        e_q = int'(m_q[i]); e_sc = int'(m_sc[i]);
        e_ten = 0; e_mode = 0; e_busy = 0;
        e_done = m_done[i]; e_err = m_err[i];
      end
      chk({p, "_q"}, int'(q_o[i]), e_q);
      chk({p, "_t_en"}, int'(ten_o[i]), int'(e_ten));
      if (e_ten) chk({p, "_mode"}, int'(mode_o[i]), int'(e_mode));
      chk({p, "_busy"}, int'(busy_o[i]), int'(e_busy));
      chk({p, "_sweep_cnt"}, int'(sc_o[i]), e_sc);
      chk({p, "_done"}, int'(done_o[i]), int'(e_done));
      chk({p, "_err"}, int'(err_o[i]), int'(e_err));

      m_done[i] = 0;
      m_err[i]  = 0;
      if (m_busy[i]) begin
        if (stop) begin
          m_busy[i] = 0;
          m_q[i]    = rq[i][m_idx[i]];
          m_sc[i]   = rsc[i][m_idx[i]];
        end else if (m_idx[i] == m_len[i] - 1) begin
          m_busy[i] = 0;
          m_q[i]    = rq[i][m_idx[i]];
          m_sc[i]   = m_fsc[i];
          m_done[i] = 1;
        end else begin
          m_idx[i]++;
        end
      end else if (start && !stop) begin
        if (lo <= hi) begin
          build(i, int'(m_q[i]), int'(lo), int'(hi), int'(n_sweeps));
          m_busy[i] = 1;
          m_idx[i]  = 0;
          m_n[i]    = n_sweeps;
          m_sc[i]   = '0;
        end else begin
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic cycle(input bit s, input bit p, input int l, input int h, input int n);
    bit pe;
    @(posedge clk);
    #1;
    pe = p;
    // Keep continuous runs inside the precomputed trajectory.
    for (int i = 0; i < 2; i++)
      if (m_busy[i] && m_n[i] == 0 && m_idx[i] > m_len[i] - 20) pe = 1;
    start = s; stop = pe; lo = 4'(l); hi = 4'(h); n_sweeps = 4'(n);
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; start = 0; stop = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    eval_cycle();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1]) && k < 800) begin
      cycle(0, 0, 0, 0, 0);
      k++;
    end
    chk("wait_idle_timeout", int'(m_busy[0] || m_busy[1]), 0);
  endtask

  initial begin
    int k;
    model_reset();

    // Reset held mid-run.
    do_reset();
    cycle(1, 0, 1, 10, 0);
    repeat (5) cycle(0, 0, 1, 10, 0);
    do_reset();
    chk("t1_q", int'(q_o[0]), 0);
    chk("t1_busy", int'(busy_o[0]), 0);
    chk("t1_sweep_cnt", int'(sc_o[0]), 0);

    // Single sweep 3..6 from q=0 with dwell 2.
    cycle(1, 0, 3, 6, 1);
    for (int j = 0; j < 14; j++) begin
      cycle(0, 0, 3, 6, 1);
      chk($sformatf("t2_q%0d", j), int'(q_o[0]), t2_exp[j]);
    end
    cycle(0, 0, 3, 6, 1);
    chk("t2_done", int'(done_o[0]), 1);
    chk("t2_sweep_cnt", int'(sc_o[0]), 1);
    cycle(0, 0, 3, 6, 1);
    chk("t2_done_pulse", int'(done_o[0]), 0);
    wait_idle();

    // Rejected start.
    cycle(1, 0, 9, 4, 0);
    cycle(0, 0, 9, 4, 0);
    chk("t3_err", int'(err_o[0]), 1);
    chk("t3_busy", int'(busy_o[0]), 0);
    cycle(0, 0, 9, 4, 0);
    chk("t3_err_pulse", int'(err_o[0]), 0);

    // Continuous triangle, stopped at q=4 going up.
    cycle(1, 0, 2, 5, 0);
    k = 0;
    while (k < 200 && !(m_busy[0] && m_idx[0] + 1 < m_len[0] &&
                        rq[0][m_idx[0]] == 4'd4 && rq[0][m_idx[0] + 1] == 4'd5 &&
                        rsc[0][m_idx[0]] != 4'd0)) begin
      cycle(0, 0, 2, 5, 0);
      k++;
    end
    chk("t4_found", int'(k < 200), 1);
    cycle(0, 1, 2, 5, 0);
    cycle(0, 0, 2, 5, 0);
    chk("t4_q", int'(q_o[0]), 4);
    chk("t4_busy", int'(busy_o[0]), 0);
    chk("t4_done", int'(done_o[0]), 0);
    wait_idle();

    // Park q at 12, then seek down to 5 while start pulses are ignored.
    cycle(1, 0, 12, 12, 1);
    wait_idle();
    cycle(1, 0, 5, 7, 1);
    cycle(0, 0, 5, 7, 1);
    chk("t5_q", int'(q_o[0]), 12);
    chk("t5_mode", int'(mode_o[0]), 1);
    for (int j = 0; j < 40; j++) cycle((j % 3) == 0, 0, j % 16, 15, 3);
    wait_idle();

    // lo==hi on the DWELL=0 instance, then start+stop together.
    cycle(1, 0, 8, 8, 2);
    wait_idle();
    chk("t6_q", int'(q_o[1]), 8);
    chk("t6_sweep_cnt", int'(sc_o[1]), 2);
    cycle(1, 1, 3, 9, 1);
    cycle(0, 0, 3, 9, 1);
    chk("t6_busy", int'(busy_o[1]), 0);

    // Randomized traffic.
    for (int j = 0; j < 4000; j++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)));
      if (j == 2000) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
